gth_lane_packer: RTL and testbench

Parametrised pixel-to-transceiver packer, successor to the fixed 3-channel, 10-bit, 2-sample GTH serializer front end. It accepts per-channel pixel samples over a valid/ready stream and packs SAMPLES_PER_WORD samples per channel into one transceiver user word. Packed words are buffered in a FIFO and released on a transceiver word strobe. When no packed word is ready, it inserts idle words and tracks frame alignment. It sits between the video pipeline and the gtwizard user-data port, all in the single clk domain.

---
 rtl/gth_lane_pkg.sv | 29 ++
 rtl/gth_lane_packer_if.sv | 30 +++
 rtl/gth_word_fifo.sv | 72 +++++++
 rtl/gth_lane_packer.sv | 194 +++++++++++++++++++
 tb/tb_gth_lane_packer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gth_lane_pkg.sv
// Shared types and helpers for the GTH lane packer: FSM state encoding,
// default idle symbol, slot placement and saturating counter arithmetic.
package gth_lane_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      RUN      = 2'd2
   } state_e;

   // Comma-like idle symbol placed in every slot of an idle word.
   localparam logic [9:0] DEF_IDLE_PATTERN = 10'h17C;

   localparam int CNT_W = 16;

   // Flat slot index of the sample accepted at word position pos for channel ch.
   function automatic int slot_index(input int ch, input int pos, input int spw,
                                     input bit msb_first);
      int k;
      k = msb_first ? (spw - 1 - pos) : pos;
      return ch * spw + k;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/gth_lane_packer_if.sv
// Pixel stream input and transceiver user-word output of the lane packer.
// master = upstream driver / transceiver side, slave = packer.
interface gth_lane_packer_if #(
   parameter int NUM_CH           = 3,
   parameter int SAMPLE_W         = 10,
   parameter int SAMPLES_PER_WORD = 2
);
   localparam int IN_W  = NUM_CH * SAMPLE_W;
   localparam int OUT_W = IN_W * SAMPLES_PER_WORD;

   logic             s_valid;
   logic             s_ready;
   logic [IN_W-1:0]  s_data;
   logic             s_sof;

   logic             tx_ce;
   logic [OUT_W-1:0] tx_data;
   logic             tx_is_idle;
   logic             tx_sof;

   modport master (
      output s_valid, s_data, s_sof, tx_ce,
      input  s_ready, tx_data, tx_is_idle, tx_sof
   );

   modport slave (
      input  s_valid, s_data, s_sof, tx_ce,
      output s_ready, tx_data, tx_is_idle, tx_sof
   );
endinterface

// File: rtl/gth_word_fifo.sv
// Synchronous first-word-fall-through FIFO for packed transceiver words.
// Level is registered; a push is visible in level/empty on the next cycle.
module gth_word_fifo #(
   parameter int WIDTH = 61,
   parameter int DEPTH = 8,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // Pointer and level next-state; flush empties the FIFO in one cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Word storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/gth_lane_packer.sv
// Packs SAMPLES_PER_WORD per-channel pixel samples into one transceiver user
// word, buffers words in a FIFO and releases them on tx_ce, substituting idle
// words when nothing is buffered. Tracks frame alignment via s_sof.
module gth_lane_packer
   import gth_lane_pkg::*;
#(
   parameter int                  NUM_CH           = 3,
   parameter int                  SAMPLE_W         = 10,
   parameter int                  SAMPLES_PER_WORD = 2,
   parameter int                  FIFO_DEPTH       = 8,
   parameter logic [SAMPLE_W-1:0] IDLE_PATTERN     = SAMPLE_W'(DEF_IDLE_PATTERN),
   parameter bit                  MSB_FIRST        = 1'b0,
   parameter int                  LVL_W            = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   gth_lane_packer_if.slave      bus,
   output logic [LVL_W-1:0]      fifo_level,
   output logic [CNT_W-1:0]      underflow_cnt,
   output logic [CNT_W-1:0]      align_err_cnt
);
   localparam int IN_W   = NUM_CH * SAMPLE_W;
   localparam int WORD_W = IN_W * SAMPLES_PER_WORD;
   localparam int POS_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
   localparam logic [WORD_W-1:0] IDLE_WORD = {(NUM_CH * SAMPLES_PER_WORD){IDLE_PATTERN}};

   state_e            state_q, state_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic              acc_sof_q, acc_sof_d;
   logic [WORD_W-1:0] tx_data_q, tx_data_d;
   logic              tx_idle_q, tx_idle_d;
   logic              tx_sof_q, tx_sof_d;
   logic [CNT_W-1:0]  uf_q, uf_d;
   logic [CNT_W-1:0]  ae_q, ae_d;

   logic              s_ready_c;
   logic              accept;
   logic              take;
   logic [POS_W-1:0]  wpos;
   logic              word_sof;
   logic              push, pop, flush;
   logic [WORD_W:0]   fifo_head;
   logic              fifo_full, fifo_empty;

   // Input handshake: ready only while enabled and with room in RUN.
   always_comb begin
      s_ready_c = 1'b0;
      if (enable) begin
         case (state_q)
            WAIT_SOF: s_ready_c = 1'b1;
            RUN:      s_ready_c = !fifo_full;
            default:  s_ready_c = 1'b0;
         endcase
      end
   end

   assign accept = bus.s_valid && s_ready_c;

   // FSM next state and packer: place accepted samples, detect word completion
   // and realign on an early SOF.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      acc_d     = acc_q;
      acc_sof_d = acc_sof_q;
      ae_d      = ae_q;
      take      = 1'b0;
      wpos      = pos_q;
      word_sof  = acc_sof_q;
      push      = 1'b0;
      flush     = 1'b0;

      if (!enable) begin
         state_d = IDLE;
         flush   = 1'b1;
         pos_d   = '0;
      end else begin
         case (state_q)
            IDLE: state_d = WAIT_SOF;
            WAIT_SOF: begin
               if (accept && bus.s_sof) begin
                  take    = 1'b1;
                  wpos    = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  take = 1'b1;
                  if (bus.s_sof && (pos_q != '0)) begin
                     wpos = '0;
                     ae_d = sat_inc16(ae_q);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (take) begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc_d[slot_index(c, int'(wpos), SAMPLES_PER_WORD, MSB_FIRST) * SAMPLE_W +: SAMPLE_W]
               = bus.s_data[c * SAMPLE_W +: SAMPLE_W];
         end
         if (wpos == '0) begin
            acc_sof_d = bus.s_sof;
            word_sof  = bus.s_sof;
         end
         if (wpos == POS_W'(SAMPLES_PER_WORD - 1)) begin
            push  = 1'b1;
            pos_d = '0;
         end else begin
            pos_d = wpos + POS_W'(1);
         end
      end
   end

   // Output word selection on transceiver strobes; idle words in RUN count as underflow.
   always_comb begin
      tx_data_d = tx_data_q;
      tx_idle_d = tx_idle_q;
      tx_sof_d  = tx_sof_q;
      uf_d      = uf_q;
      pop       = 1'b0;
      if (bus.tx_ce) begin
         if (!fifo_empty) begin
            pop       = 1'b1;
            tx_data_d = fifo_head[WORD_W-1:0];
            tx_idle_d = 1'b0;
            tx_sof_d  = fifo_head[WORD_W];
         end else begin
            tx_data_d = IDLE_WORD;
            tx_idle_d = 1'b1;
            tx_sof_d  = 1'b0;
            if (enable && (state_q == RUN)) uf_d = sat_inc16(uf_q);
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         pos_q     <= '0;
         acc_sof_q <= 1'b0;
         tx_data_q <= IDLE_WORD;
         tx_idle_q <= 1'b1;
         tx_sof_q  <= 1'b0;
         uf_q      <= '0;
         ae_q      <= '0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         acc_sof_q <= acc_sof_d;
         tx_data_q <= tx_data_d;
         tx_idle_q <= tx_idle_d;
         tx_sof_q  <= tx_sof_d;
         uf_q      <= uf_d;
         ae_q      <= ae_d;
      end
   end

   // Partial-word accumulator; only meaningful up to the current position.
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
   end

   gth_word_fifo #(
      .WIDTH (WORD_W + 1),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .push   (push),
      .wdata  ({word_sof, acc_d}),
      .pop    (pop),
      .head   (fifo_head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   assign bus.s_ready    = s_ready_c;
   assign bus.tx_data    = tx_data_q;
   assign bus.tx_is_idle = tx_idle_q;
   assign bus.tx_sof     = tx_sof_q;
   assign underflow_cnt  = uf_q;
   assign align_err_cnt  = ae_q;

endmodule

// File: tb/tb_gth_lane_packer.sv
// Scoreboard bench for gth_lane_packer: two instances (LSB-first and
// MSB-first slot order) share one stimulus stream; expected words are queued
// when samples are issued and popped by a monitor on each tx_ce.
`timescale 1ns/1ps
module tb_gth_lane_packer;
   localparam int WW = 60;
   localparam int LW = 4;
   localparam logic [WW-1:0] IDLE_W = {6{10'h17C}};

   typedef struct packed {
      logic [WW-1:0] data;
      logic          sof;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic enable = 1'b0;
   int   ce_mode = 0;
   bit   ce_tog = 1'b0;
   bit   run_model = 1'b0;
   int   exp_uf = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   logic [LW-1:0] lvl0, lvl1;
   logic [15:0]   uf0, ae0, uf1, ae1;

   always #5 clk = ~clk;

   gth_lane_packer_if #(.NUM_CH(3), .SAMPLE_W(10), .SAMPLES_PER_WORD(2)) bus0 ();
   gth_lane_packer_if #(.NUM_CH(3), .SAMPLE_W(10), .SAMPLES_PER_WORD(2)) bus1 ();

   assign bus1.s_valid = bus0.s_valid;
   assign bus1.s_data  = bus0.s_data;
   assign bus1.s_sof   = bus0.s_sof;
   assign bus1.tx_ce   = bus0.tx_ce;

   gth_lane_packer #(.MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .resetn(resetn), .enable(enable), .bus(bus0),
      .fifo_level(lvl0), .underflow_cnt(uf0), .align_err_cnt(ae0));

   gth_lane_packer #(.MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .resetn(resetn), .enable(enable), .bus(bus1),
      .fifo_level(lvl1), .underflow_cnt(uf1), .align_err_cnt(ae1));

   function automatic logic [29:0] px(input int r, input int g, input int b);
      return {10'(b), 10'(g), 10'(r)};
   endfunction

   function automatic logic [WW-1:0] pack(input logic [29:0] a0, input logic [29:0] a1,
                                          input bit msb);
      logic [WW-1:0] w;
      w = '0;
      for (int c = 0; c < 3; c++) begin
         w[(2*c)*10 +: 10]   = msb ? a1[c*10 +: 10] : a0[c*10 +: 10];
         w[(2*c+1)*10 +: 10] = msb ? a0[c*10 +: 10] : a1[c*10 +: 10];
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [29:0] a0, input logic [29:0] a1, input bit sof);
      q0.push_back('{data: pack(a0, a1, 1'b0), sof: sof});
      q1.push_back('{data: pack(a0, a1, 1'b1), sof: sof});
   endtask

   task automatic check_out(input int idx, input logic [WW-1:0] d, input logic idle,
                            input logic sof);
      exp_t e;
      int   sz;
      checks++;
      if (idle) begin
         if (d !== IDLE_W || sof !== 1'b0) begin
            errors++;
            $display("FAIL idle_word dut%0d: got data=%h sof=%b want data=%h sof=0",
                     idx, d, sof, IDLE_W);
         end
      end else begin
         sz = (idx == 0) ? q0.size() : q1.size();
         if (sz == 0) begin
            errors++;
            $display("FAIL unexpected_word dut%0d: got data=%h sof=%b want idle", idx, d, sof);
         end else begin
            if (idx == 0) e = q0.pop_front();
            else          e = q1.pop_front();
            if (d !== e.data || sof !== e.sof) begin
               errors++;
               $display("FAIL word dut%0d: got data=%h sof=%b want data=%h sof=%b",
                        idx, d, sof, e.data, e.sof);
            end
         end
      end
   endtask

   // Transceiver strobe generator: 0 = off, 1 = every cycle, 2 = every 2nd cycle.
   initial begin
      bus0.tx_ce = 1'b0;
      forever begin
         @(negedge clk);
         case (ce_mode)
            1: bus0.tx_ce = 1'b1;
            2: begin ce_tog = ~ce_tog; bus0.tx_ce = ce_tog; end
            default: bus0.tx_ce = 1'b0;
         endcase
      end
   end

   // Monitor: every strobe either pops an expected word or must be an idle word.
   initial begin : monitor
      logic ce, rm;
      forever begin
         @(posedge clk);
         ce = bus0.tx_ce;
         rm = run_model;
         #1;
         if (ce && resetn) begin
            check_out(0, bus0.tx_data, bus0.tx_is_idle, bus0.tx_sof);
            check_out(1, bus1.tx_data, bus1.tx_is_idle, bus1.tx_sof);
            if (bus0.tx_is_idle && rm) exp_uf++;
         end
      end
   end

   task automatic set_ce(input int m);
      @(posedge clk);
      ce_mode = m;
   endtask

   task automatic send(input int r, input int g, input int b, input bit sof);
      bit done;
      done = 1'b0;
      @(negedge clk);
      bus0.s_valid = 1'b1;
      bus0.s_data  = px(r, g, b);
      bus0.s_sof   = sof;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk);
         if (bus0.s_ready) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no s_ready want accept of r=%0d", r);
      end
      #1;
      bus0.s_valid = 1'b0;
      bus0.s_sof   = 1'b0;
      if (done && sof && enable) run_model = 1'b1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d words pending want 0", q0.size());
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_s_ready"}, 64'(bus0.s_ready), 64'd0);
      chk({tag, "_tx_is_idle"}, 64'(bus0.tx_is_idle), 64'd1);
      chk({tag, "_tx_data"}, 64'(bus0.tx_data), 64'(IDLE_W));
      chk({tag, "_tx_sof"}, 64'(bus0.tx_sof), 64'd0);
      chk({tag, "_fifo_level"}, 64'(lvl0), 64'd0);
      chk({tag, "_underflow"}, 64'(uf0), 64'd0);
      chk({tag, "_align_err"}, 64'(ae0), 64'd0);
   endtask

   task automatic do_reset();
      set_ce(0);
      @(negedge clk);
      enable    = 1'b0;
      resetn    = 1'b0;
      run_model = 1'b0;
      exp_uf    = 0;
      q0.delete();
      q1.delete();
      #1;
      check_reset_values("reset");
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no end of test want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus0.s_valid = 1'b0;
      bus0.s_data  = '0;
      bus0.s_sof   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("por");
      resetn = 1'b1;

      // Basic packing, tx_ce every 2nd cycle
      @(negedge clk);
      enable = 1'b1;
      set_ce(2);
      q0.push_back('{data: {10'd6, 10'd3, 10'd5, 10'd2, 10'd4, 10'd1}, sof: 1'b1});
      q1.push_back('{data: {10'd3, 10'd6, 10'd2, 10'd5, 10'd1, 10'd4}, sof: 1'b1});
      send(1, 2, 3, 1'b1);
      send(4, 5, 6, 1'b0);
      wait_drain();
      repeat (4) @(negedge clk);
      chk("t1_underflow", 64'(uf0), 64'(exp_uf));
      chk("t1_align_err", 64'(ae0), 64'd0);

      // Idle words and underflow accounting, tx_ce every cycle, sparse input
      do_reset();
      enable = 1'b1;
      set_ce(1);
      repeat (6) @(negedge clk);
      chk("t3_no_uf_wait_sof", 64'(uf0), 64'd0);
      expect_word(px(10, 20, 30), px(11, 21, 31), 1'b1);
      expect_word(px(12, 22, 32), px(13, 23, 33), 1'b0);
      send(10, 20, 30, 1'b1);
      repeat (3) @(negedge clk);
      send(11, 21, 31, 1'b0);
      repeat (3) @(negedge clk);
      send(12, 22, 32, 1'b0);
      repeat (4) @(negedge clk);
      send(13, 23, 33, 1'b0);
      wait_drain();
      repeat (3) @(negedge clk);
      chk("t3_underflow", 64'(uf0), 64'(exp_uf));
      chk("t3_underflow_msb", 64'(uf1), 64'(exp_uf));

      // SOF at position 1 discards the partial word
      expect_word(px(100, 101, 102), px(200, 201, 202), 1'b1);
      send(7, 8, 9, 1'b1);
      send(100, 101, 102, 1'b1);
      send(200, 201, 202, 1'b0);
      wait_drain();
      chk("t5_align_err", 64'(ae0), 64'd1);
      chk("t5_align_err_msb", 64'(ae1), 64'd1);

      // Backpressure: fill the FIFO with tx_ce held low
      set_ce(0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         expect_word(px(i*8+1, i*8+2, i*8+3), px(i*8+4, i*8+5, i*8+6), (i == 0));
         send(i*8+1, i*8+2, i*8+3, (i == 0));
         send(i*8+4, i*8+5, i*8+6, 1'b0);
      end
      @(negedge clk);
      chk("t4_level_full", 64'(lvl0), 64'd8);
      chk("t4_level_full_msb", 64'(lvl1), 64'd8);
      chk("t4_s_ready_full", 64'(bus0.s_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk("t4_s_ready_held", 64'(bus0.s_ready), 64'd0);
      for (int i = 8; i < 10; i++) begin
         expect_word(px(i*8+1, i*8+2, i*8+3), px(i*8+4, i*8+5, i*8+6), 1'b0);
      end
      fork
         begin
            for (int i = 8; i < 10; i++) begin
               send(i*8+1, i*8+2, i*8+3, 1'b0);
               send(i*8+4, i*8+5, i*8+6, 1'b0);
            end
         end
         set_ce(2);
      join
      wait_drain();
      repeat (2) @(negedge clk);
      chk("t4_level_empty", 64'(lvl0), 64'd0);

      // enable dropped mid-frame flushes FIFO and packer
      set_ce(0);
      repeat (2) @(negedge clk);
      send(500, 501, 502, 1'b0);
      send(503, 504, 505, 1'b0);
      send(506, 507, 508, 1'b0);
      @(negedge clk);
      chk("t6_level_before", 64'(lvl0), 64'd1);
      enable    = 1'b0;
      run_model = 1'b0;
      @(negedge clk);
      chk("t6_level_flushed", 64'(lvl0), 64'd0);
      chk("t6_s_ready_off", 64'(bus0.s_ready), 64'd0);
      set_ce(1);
      set_ce(0);
      repeat (2) @(negedge clk);
      chk("t6_idle_out", 64'(bus0.tx_is_idle), 64'd1);
      chk("t6_uf_held", 64'(uf0), 64'(exp_uf));

      // reset mid-word, then samples before SOF are dropped
      enable = 1'b1;
      send(50, 51, 52, 1'b1);
      @(negedge clk);
      resetn    = 1'b0;
      run_model = 1'b0;
      exp_uf    = 0;
      q0.delete();
      q1.delete();
      #1;
      check_reset_values("t6_reset");
      @(negedge clk);
      resetn = 1'b1;
      set_ce(2);
      send(60, 61, 62, 1'b0);
      send(63, 64, 65, 1'b0);
      expect_word(px(70, 71, 72), px(73, 74, 75), 1'b1);
      send(70, 71, 72, 1'b1);
      send(73, 74, 75, 1'b0);
      wait_drain();
      repeat (4) @(negedge clk);
      chk("t6_final_underflow", 64'(uf0), 64'(exp_uf));
      chk("t6_final_align_err", 64'(ae0), 64'd0);
      chk("t6_final_level", 64'(lvl0), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
